// File: rtl/osd_pkg.sv
`default_nettype none
// ============================================================================
// osd_pkg : shared constants and FSM state type for the OSD tile writer
// Rev 1.0
// ============================================================================
package osd_pkg;

  localparam logic [7:0] OSD_PFX_TILE = 8'hFD;
  localparam logic [7:0] OSD_PFX_EN   = 8'hFE;
  localparam int         OSD_INV_BIT  = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } osd_state_e;

endpackage
`default_nettype wire

// File: rtl/osd_clear_seq.sv
`default_nettype none
// ============================================================================
// osd_clear_seq : clear-screen sweep index counter with last detect and done
// Rev 1.0
// ============================================================================
module osd_clear_seq #(
  parameter int N  = 1536,
  parameter int AW = 11
) (
  input  logic          clk_pixel,
  input  logic          rstn,
  input  logic          i_start,
  input  logic          i_advance,
  output logic [AW-1:0] o_index,
  output logic          o_last,
  output logic          o_done
);

  localparam logic [AW-1:0] c_last_idx = AW'(N - 1);

  logic [AW-1:0] r_index;
  logic          r_done;

  // Index holds whenever the port is taken by an SPI write.
  always_ff @(posedge clk_pixel or negedge rstn) begin
    if (!rstn) begin
      r_index <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= i_advance && (r_index == c_last_idx);
      if (i_start) begin
        r_index <= '0;
      end else if (i_advance) begin
        r_index <= r_index + 1'b1;
      end
    end
  end

  assign o_index = r_index;
  assign o_last  = (r_index == c_last_idx);
  assign o_done  = r_done;

endmodule
`default_nettype wire

// File: rtl/osd_tile_writer.sv
`default_nettype none
// ============================================================================
// osd_tile_writer : arbitrates SPI, clear sweep and local writes onto one
//                   registered tile-map write port; owns the OSD enable bit
// Rev 1.0
// ============================================================================
module osd_tile_writer
  import osd_pkg::*;
#(
  parameter int         c_chars_x    = 64,
  parameter int         c_chars_y    = 24,
  parameter int         c_inverse    = 1,
  parameter bit         c_init_on    = 1'b1,
  parameter logic [7:0] c_clear_char = 8'h20,
  localparam int        N            = c_chars_x * c_chars_y,
  localparam int        AW           = $clog2(N),
  localparam int        DW           = 8 + c_inverse
) (
  input  logic          clk_pixel,
  input  logic          rstn,
  input  logic          i_spi_wr,
  input  logic [31:0]   i_spi_addr,
  input  logic [7:0]    i_spi_data,
  input  logic          i_clear,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [AW-1:0] i_req_addr,
  input  logic [DW-1:0] i_req_data,
  output logic          o_busy,
  output logic          o_clear_done,
  output logic          o_tile_we,
  output logic [AW-1:0] o_tile_addr,
  output logic [DW-1:0] o_tile_data,
  output logic          o_osd_en
);

  localparam logic [AW:0]   c_n          = (AW + 1)'(N);
  localparam logic [DW-1:0] c_clear_word = DW'(c_clear_char);

  osd_state_e    r_state;
  osd_state_e    w_state_next;
  logic          w_spi_tile;
  logic          w_spi_en;
  logic          w_sweep_issue;
  logic          w_req_ready;
  logic          w_req_fire;
  logic          w_seq_start;
  logic          w_seq_last;
  logic          w_seq_done;
  logic [AW-1:0] w_seq_index;
  logic [AW-1:0] w_spi_idx;
  logic [DW-1:0] w_spi_word;
  logic          w_spi_in_range;
  logic          w_req_in_range;
  logic          w_spi_addr_unused;

  logic          r_tile_we;
  logic [AW-1:0] r_tile_addr;
  logic [DW-1:0] r_tile_data;
  logic          r_osd_en;

  assign w_spi_idx      = i_spi_addr[AW-1:0];
  assign w_spi_tile     = i_spi_wr && (i_spi_addr[31:24] == OSD_PFX_TILE);
  assign w_spi_en       = i_spi_wr && (i_spi_addr[31:24] == OSD_PFX_EN);
  assign w_spi_in_range = ({1'b0, w_spi_idx} < c_n);
  assign w_req_in_range = ({1'b0, i_req_addr} < c_n);
  assign w_req_fire     = i_req_valid && w_req_ready;
  assign w_spi_addr_unused = ^i_spi_addr[23:AW];

  if (c_inverse != 0) begin : g_inverse
    assign w_spi_word = {i_spi_addr[OSD_INV_BIT], i_spi_data};
  end else begin : g_plain
    assign w_spi_word = i_spi_data;
  end

  always_ff @(posedge clk_pixel or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // SPI always owns the port; the sweep and local requester only get idle cycles.
  always_comb begin
    w_state_next  = r_state;
    w_sweep_issue = 1'b0;
    w_req_ready   = 1'b0;
    w_seq_start   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = !i_clear && !w_spi_tile;
        if (i_clear) begin
          w_state_next = ST_CLEAR;
          w_seq_start  = 1'b1;
        end
      end
      ST_CLEAR: begin
        w_sweep_issue = !w_spi_tile;
        if (w_sweep_issue && w_seq_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  osd_clear_seq #(
    .N  (N),
    .AW (AW)
  ) u_clear_seq (
    .clk_pixel (clk_pixel),
    .rstn      (rstn),
    .i_start   (w_seq_start),
    .i_advance (w_sweep_issue),
    .o_index   (w_seq_index),
    .o_last    (w_seq_last),
    .o_done    (w_seq_done)
  );

  // Out-of-range indices still complete their transfer but never strobe the RAM.
  always_ff @(posedge clk_pixel or negedge rstn) begin
    if (!rstn) begin
      r_tile_we   <= 1'b0;
      r_tile_addr <= '0;
      r_tile_data <= '0;
      r_osd_en    <= c_init_on;
    end else begin
      r_tile_we <= 1'b0;
      if (w_spi_tile) begin
        r_tile_we   <= w_spi_in_range;
        r_tile_addr <= w_spi_idx;
        r_tile_data <= w_spi_word;
      end else if (w_sweep_issue) begin
        r_tile_we   <= 1'b1;
        r_tile_addr <= w_seq_index;
        r_tile_data <= c_clear_word;
      end else if (w_req_fire) begin
        r_tile_we   <= w_req_in_range;
        r_tile_addr <= i_req_addr;
        r_tile_data <= i_req_data;
      end
      if (w_spi_en) begin
        r_osd_en <= i_spi_data[0];
      end
    end
  end

  assign o_req_ready  = w_req_ready;
  assign o_busy       = (r_state == ST_CLEAR);
  assign o_clear_done = w_seq_done;
  assign o_tile_we    = r_tile_we;
  assign o_tile_addr  = r_tile_addr;
  assign o_tile_data  = r_tile_data;
  assign o_osd_en     = r_osd_en;

endmodule
`default_nettype wire

// File: doc/osd_tile_writer.md
# osd_tile_writer

Write-port scheduler for the OSD tile map (character RAM) and OSD enable register. It arbitrates three write sources onto a single registered tile-map write port: SPI slave writes, a hardware clear-screen sweep, and a local on-chip text requester with a valid/ready handshake. It sits between the SPI slave and the tile RAM inside the OSD text-window path, and owns the enable register.

## Interface
- c_chars_x, 64, window width in characters
- c_chars_y, 24, window height in characters
- c_inverse, 1, 1: tile entries carry an inverse bit (9-bit data); 0: 8-bit data
- c_init_on, 1, reset value of o_osd_en
- c_clear_char, 8'h20, character written by the clear sweep (inverse bit 0)
- derived: N = c_chars_x*c_chars_y; AW = $clog2(N); DW = 8+c_inverse

Ports:
- clk_pixel  in  1  pixel clock; the only clock
- rstn  in  1  asynchronous, active-low reset
- i_spi_wr  in  1  single-cycle write strobe from SPI slave (no backpressure)
- i_spi_addr  in  32  SPI byte address
- i_spi_data  in  8  SPI write data
- i_clear  in  1  single-cycle clear-screen request
- i_req_valid  in  1  local write request valid
- o_req_ready  out  1  local write accepted when valid&ready
- i_req_addr  in  AW  local tile index
- i_req_data  in  DW  local tile data (MSB = inverse when c_inverse)
- o_busy  out  1  clear sweep in progress
- o_clear_done  out  1  one-cycle pulse after last clear write issued
- o_tile_we  out  1  tile RAM write enable
- o_tile_addr  out  AW  tile RAM address
- o_tile_data  out  DW  tile RAM data
- o_osd_en  out  1  OSD display enable

## Operation
- SPI decode: addr[31:24]==8'hFD -> tile write, index addr[AW-1:0], data {addr[16], data} (c_inverse=1) or data. addr[31:24]==8'hFE -> o_osd_en <= data[0]. Other prefixes ignored.
- Priority per cycle: SPI tile write > clear sweep > local request. SPI is never stalled or dropped.
- FSM: IDLE, CLEAR.
  - IDLE: i_clear -> CLEAR, sweep counter = 0. Local requests serviced.
  - CLEAR: each cycle without SPI tile write, issue write {0,c_clear_char} at counter, counter++. SPI tile write cycle: SPI takes the port, counter holds. After index N-1 issued -> IDLE, o_clear_done pulses.
  - i_clear while in CLEAR: ignored (no restart).
- o_req_ready = (state==IDLE) && !i_clear && !(SPI tile write this cycle). Combinational. Requester must hold addr/data while valid&&!ready.
- Index range: any write (SPI or local) with index >= N is consumed (local handshake completes) but produces no o_tile_we.
- SPI writes during CLEAR take effect immediately; cells not yet swept are later overwritten by the sweep.
- 0xFE writes act in every state, independent of the tile port.

## Timing
- Reset values: o_tile_we=0, o_tile_addr=0, o_tile_data=0, o_busy=0, o_clear_done=0, o_osd_en=c_init_on, state IDLE, counter 0.
- All tile-port outputs registered: acceptance in cycle t -> o_tile_we/addr/data valid in cycle t+1 for one cycle.
- o_osd_en updates cycle after i_spi_wr.
- Clear with no SPI interference: i_clear at t -> o_busy high t+1 .. t+N; writes at t+2 .. t+N+1; o_clear_done pulses t+N+1; o_req_ready high again from t+N+1.
- Each SPI tile write during CLEAR extends sweep by exactly one cycle.
- rstn asserted mid-sweep: immediate return to IDLE, no further writes, partial clear remains in RAM.
- At most one write per cycle on the tile port; never two sources granted in one cycle.

## Structure
- Package osd_pkg: prefix constants OSD_PFX_TILE=8'hFD, OSD_PFX_EN=8'hFE, inverse bit index 16, FSM state enum.
- One sub-module: osd_clear_seq (sweep counter, hold input, last-index detect, done pulse); arbitration, decode and output registers stay in top.

## Test plan
- Reset with c_init_on=1 -> o_osd_en=1, o_tile_we=0; SPI write 0xFE000000 data 0x00 -> o_osd_en=0 next cycle.
- SPI write 0xFD010005 data 0x41 -> next cycle o_tile_we=1, addr 5, data 9'h141.
- Local req addr 10 data 0x042 held valid while SPI writes 0xFD000003 same cycle -> SPI written first; local written one cycle later; ready low only in conflict cycle.
- i_clear with N=1536 -> 1536 writes of 0x020 addr 0..1535, o_clear_done at t+1537; SPI write mid-sweep adds one cycle, its data lands.
- Local req addr 1536 (>= N) -> handshake completes, no o_tile_we.
- rstn low at sweep index 100 -> o_busy=0, no writes after reset, o_osd_en=c_init_on.
